// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared feature-stream types, defaults and width helpers.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

  localparam int c_DATA_WIDTH   = 16;
  localparam int c_NUM_CHANNELS = 6;

  typedef logic signed [c_DATA_WIDTH-1:0] feature_t;
  typedef feature_t [0:c_NUM_CHANNELS-1]  feature_vec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width that can hold the values 0..n inclusive (terminal-compare counters).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Address width for an n-entry storage array.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/upsample_nn_if.sv
`default_nettype none
// ============================================================================
// Module   : upsample_nn_if
// Brief    : Frame-control, input-beat and output-beat bundle of the upsampler.
// Revision : 1.0
// ============================================================================
interface upsample_nn_if #(
  parameter int DATA_WIDTH   = cnn_pkg::c_DATA_WIDTH,
  parameter int NUM_CHANNELS = cnn_pkg::c_NUM_CHANNELS
);

  logic                                    i_start;
  logic                                    i_nd;
  logic [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] i_features;
  logic                                    o_ready;
  logic [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] o_features;
  logic                                    o_nd;
  logic                                    o_last;
  logic                                    o_err;

  modport master (
    output i_start, i_nd, i_features,
    input  o_ready, o_features, o_nd, o_last, o_err
  );

  modport slave (
    input  i_start, i_nd, i_features,
    output o_ready, o_features, o_nd, o_last, o_err
  );

endinterface
`default_nettype wire

// File: rtl/upsample_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : upsample_row_buf
// Brief    : Two ping-pong row banks, one write port, one registered read port.
// Revision : 1.0
// ============================================================================
module upsample_row_buf
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DATA_WIDTH,
  parameter int NUM_CHANNELS   = c_NUM_CHANNELS,
  parameter int NUM_IN_COLUMNS = 14,
  parameter int ADDR_W         = idx_w(NUM_IN_COLUMNS)
) (
  input  wire logic                                    i_clk,
  input  wire logic                                    i_rst_n,
  input  wire logic                                    i_wr_en,
  input  wire logic                                    i_wr_sel,
  input  wire logic [ADDR_W-1:0]                       i_wr_col,
  input  wire logic [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] i_wr_data,
  input  wire logic                                    i_rd_en,
  input  wire logic                                    i_rd_sel,
  input  wire logic [ADDR_W-1:0]                       i_rd_col,
  output logic      [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] o_rd_data
);

  logic [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] r_mem [2][NUM_IN_COLUMNS];
  logic [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] r_rd_data;

  // Storage carries no reset so it can map onto plain RAM/register files.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_sel][i_wr_col] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_sel][i_rd_col];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/upsample_nn.sv
`default_nettype none
// ============================================================================
// Module   : upsample_nn
// Brief    : Nearest-neighbour 2x upsampler, each row and column emitted twice.
// Revision : 1.0
// ============================================================================
module upsample_nn
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DATA_WIDTH,
  parameter int NUM_CHANNELS   = c_NUM_CHANNELS,
  parameter int NUM_IN_COLUMNS = 14,
  parameter int NUM_IN_ROWS    = 14
) (
  input  wire logic    i_clk,
  input  wire logic    i_rst_n,
  upsample_nn_if.slave bus
);

  localparam int c_COL_W  = cnt_w(NUM_IN_COLUMNS);
  localparam int c_OCOL_W = cnt_w(2 * NUM_IN_COLUMNS);
  localparam int c_ROW_W  = cnt_w(NUM_IN_ROWS);
  localparam int c_ADDR_W = idx_w(NUM_IN_COLUMNS);

  localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(NUM_IN_COLUMNS - 1);
  localparam logic [c_OCOL_W-1:0] c_LAST_OCOL = c_OCOL_W'(2 * NUM_IN_COLUMNS - 1);
  localparam logic [c_ROW_W-1:0]  c_ROWS      = c_ROW_W'(NUM_IN_ROWS);
  localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(NUM_IN_ROWS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_start_acc;

  logic                  r_wr_sel;
  logic [c_COL_W-1:0]    r_wr_col;
  logic [c_ROW_W-1:0]    r_in_row;
  logic                  r_rd_sel;
  logic [c_OCOL_W-1:0]   r_out_col;
  logic                  r_pass;
  logic [c_ROW_W-1:0]    r_out_row;
  logic [1:0]            r_full;

  logic                  r_nd;
  logic                  r_last;
  logic                  r_err;

  logic                  w_ready;
  logic                  w_wr_acc;
  logic                  w_drop;
  logic                  w_wr_row_end;
  logic                  w_rd_act;
  logic                  w_rd_row_end;
  logic                  w_rd_last;
  logic [c_ADDR_W-1:0]   w_wr_addr;
  logic [c_ADDR_W-1:0]   w_rd_addr;
  logic [0:NUM_CHANNELS-1][DATA_WIDTH-1:0] w_rd_data;

  // ---------------------------------------------------------------- control
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_rd_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ handshake decode
  assign w_ready      = (r_state == ST_RUN) && !r_full[r_wr_sel] && (r_in_row < c_ROWS);
  assign w_wr_acc     = bus.i_nd && w_ready;
  assign w_drop       = bus.i_nd && !w_ready;
  assign w_wr_row_end = w_wr_acc && (r_wr_col == c_LAST_COL);

  assign w_rd_act     = r_full[r_rd_sel];
  assign w_rd_row_end = w_rd_act && (r_out_col == c_LAST_OCOL) && r_pass;
  assign w_rd_last    = w_rd_row_end && (r_out_row == c_LAST_ROW);

  assign w_wr_addr    = c_ADDR_W'(r_wr_col);
  assign w_rd_addr    = c_ADDR_W'(r_out_col >> 1);

  // Fill and release always hit opposite banks, so both may land on one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_sel  <= 1'b0;
      r_wr_col  <= '0;
      r_in_row  <= '0;
      r_rd_sel  <= 1'b0;
      r_out_col <= '0;
      r_pass    <= 1'b0;
      r_out_row <= '0;
      r_full    <= 2'b00;
    end else if (w_start_acc) begin
      r_wr_sel  <= 1'b0;
      r_wr_col  <= '0;
      r_in_row  <= '0;
      r_rd_sel  <= 1'b0;
      r_out_col <= '0;
      r_pass    <= 1'b0;
      r_out_row <= '0;
      r_full    <= 2'b00;
    end else begin
      if (w_wr_acc) begin
        if (w_wr_row_end) begin
          r_wr_col         <= '0;
          r_wr_sel         <= ~r_wr_sel;
          r_in_row         <= r_in_row + c_ROW_W'(1);
          r_full[r_wr_sel] <= 1'b1;
        end else begin
          r_wr_col <= r_wr_col + c_COL_W'(1);
        end
      end
      if (w_rd_act) begin
        if (r_out_col == c_LAST_OCOL) begin
          r_out_col <= '0;
          r_pass    <= ~r_pass;
        end else begin
          r_out_col <= r_out_col + c_OCOL_W'(1);
        end
        if (w_rd_row_end) begin
          r_full[r_rd_sel] <= 1'b0;
          r_rd_sel         <= ~r_rd_sel;
          r_out_row        <= r_out_row + c_ROW_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------- output flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nd   <= 1'b0;
      r_last <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_nd   <= w_rd_act;
      r_last <= w_rd_last;
      r_err  <= (r_err && !w_start_acc) || w_drop;
    end
  end

  upsample_row_buf #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_CHANNELS   (NUM_CHANNELS),
    .NUM_IN_COLUMNS (NUM_IN_COLUMNS),
    .ADDR_W         (c_ADDR_W)
  ) u_row_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_sel  (r_wr_sel),
    .i_wr_col  (w_wr_addr),
    .i_wr_data (bus.i_features),
    .i_rd_en   (w_rd_act),
    .i_rd_sel  (r_rd_sel),
    .i_rd_col  (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.o_ready    = w_ready;
  assign bus.o_features = w_rd_data;
  assign bus.o_nd       = r_nd;
  assign bus.o_last     = r_last;
  assign bus.o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_upsample_nn.sv
`default_nettype none
// ============================================================================
// Module   : tb_upsample_nn
// Brief    : Directed frames against a raster-mapping model of the upsampler.
// Revision : 1.0
// ============================================================================
module tb_upsample_nn;
  import cnn_pkg::*;

  localparam int DW        = 16;
  localparam int NCH       = 6;
  localparam int NC        = 14;
  localparam int NR        = 14;
  localparam int NPIX      = NC * NR;
  localparam int OUT_BEATS = 4 * NC * NR;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upsample_nn_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) bus ();
  upsample_nn #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .NUM_IN_COLUMNS(NC), .NUM_IN_ROWS(NR)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  upsample_nn_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(1)) bus_s ();
  upsample_nn #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(1), .NUM_IN_COLUMNS(2), .NUM_IN_ROWS(1)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat = 0;
  int n_last = 0;
  int first_nd_cyc = -1;
  int last_nd_cyc = -1;
  int acc13_cyc = -1;
  bit mon_en = 0;
  bit abort = 0;
  bit s_mon = 0;
  int s_vals[$];
  int s_lasts[$];
  int s_exp[8] = '{5, 5, -7, -7, 5, 5, -7, -7};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Input pixel (r,c) carries r*100 + c*2 + ch on channel ch.
  function automatic int in_val(input int p, input int ch);
    return (p / NC) * 100 + (p % NC) * 2 + ch;
  endfunction

  // Output beat n is raster position (n / 2NC, n % 2NC); source pixel is half of each.
  function automatic int exp_val(input int n, input int ch);
    int orow;
    int ocol;
    orow = n / (2 * NC);
    ocol = n % (2 * NC);
    return (orow / 2) * 100 + (ocol / 2) * 2 + ch;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_nd) begin
        if (beat == 0) first_nd_cyc = cyc;
        else chk("gap", cyc - last_nd_cyc, 1);
        for (int ch = 0; ch < NCH; ch++)
          chk("data", int'($signed(bus.o_features[ch])), exp_val(beat, ch));
        chk("last_flag", int'(bus.o_last), int'(beat == OUT_BEATS - 1));
        if (beat == 0)   chk("lit_b0_ch5",   int'($signed(bus.o_features[5])), 5);
        if (beat == 57)  chk("lit_b57_ch0",  int'($signed(bus.o_features[0])), 100);
        if (beat == OUT_BEATS - 1)
          chk("lit_b783_ch3", int'($signed(bus.o_features[3])), 1329);
        if (bus.o_last) n_last++;
        last_nd_cyc = cyc;
        beat++;
      end else begin
        chk("last_without_nd", int'(bus.o_last), 0);
      end
    end
    if (s_mon && bus_s.o_nd) begin
      s_vals.push_back(int'($signed(bus_s.o_features[0])));
      s_lasts.push_back(int'(bus_s.o_last));
    end
  end

  task automatic feed(input bit hold);
    int  p = 0;
    int  g = 0;
    bit  drop_seen = 0;
    bit  drop_chk = 0;
    while (p < NPIX && g < 5000 && !abort) begin
      @(negedge clk);
      g++;
      if (abort) break;
      if (drop_chk) begin
        chk("err_set", int'(bus.o_err), 1);
        drop_chk = 0;
      end
      if (bus.o_ready) begin
        bus.i_nd = 1'b1;
        for (int ch = 0; ch < NCH; ch++) bus.i_features[ch] = DW'(in_val(p, ch));
        if (p == NC - 1) acc13_cyc = cyc + 1;
        p++;
      end else if (hold) begin
        bus.i_nd = 1'b1;
        for (int ch = 0; ch < NCH; ch++) bus.i_features[ch] = 16'h7ABC;
        if (!drop_seen) begin
          drop_seen = 1;
          chk("accepted_before_drop", p, 2 * NC);
          chk("err_before_drop", int'(bus.o_err), 0);
          drop_chk = 1;
        end
      end else begin
        bus.i_nd = 1'b0;
      end
    end
    if (!abort) begin
      chk("fed_all", p, NPIX);
      if (hold) chk("drop_seen", int'(drop_seen), 1);
      @(negedge clk);
    end
    bus.i_nd = 1'b0;
  endtask

  task automatic new_frame();
    beat = 0;
    n_last = 0;
    first_nd_cyc = -1;
    mon_en = 1;
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("err_clear_on_start", int'(bus.o_err), 0);
  endtask

  task automatic wait_frame();
    int g = 0;
    while (beat < OUT_BEATS && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    chk("beat_count", beat, OUT_BEATS);
    chk("last_count", n_last, 1);
    chk("idle_ready", int'(bus.o_ready), 0);
  endtask

  initial begin
    int g;
    int sp;
    bus.i_start = 1'b0;   bus.i_nd = 1'b0;   bus.i_features = '0;
    bus_s.i_start = 1'b0; bus_s.i_nd = 1'b0; bus_s.i_features = '0;
    repeat (3) @(negedge clk);
    chk("rst_nd", int'(bus.o_nd), 0);
    chk("rst_last", int'(bus.o_last), 0);
    chk("rst_err", int'(bus.o_err), 0);
    chk("rst_ready", int'(bus.o_ready), 0);
    for (int ch = 0; ch < NCH; ch++) chk("rst_features", int'($signed(bus.o_features[ch])), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_pre", int'(bus.o_ready), 0);

    // Frame 1: plain feed, latency and gap-free replay.
    new_frame();
    feed(0);
    wait_frame();
    chk("first_nd_latency", first_nd_cyc, acc13_cyc + 1);

    // Frame 2: i_nd held high throughout.
    new_frame();
    feed(1);
    wait_frame();

    // Frame 3: i_start pulsed mid-frame must be ignored.
    new_frame();
    fork
      feed(0);
      begin
        g = 0;
        while (beat < 100 && g < 3000) begin @(negedge clk); g++; end
        chk("reach_beat100", int'(beat >= 100), 1);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
      end
    join
    wait_frame();

    // Frame 4: asynchronous reset mid-frame, then a clean frame.
    new_frame();
    fork
      feed(0);
      begin
        g = 0;
        while (beat < 300 && g < 3000) begin @(negedge clk); g++; end
        chk("reach_beat300", int'(beat >= 300), 1);
        chk("nd_before_reset", int'(bus.o_nd), 1);
        #2;
        mon_en = 0;
        abort = 1;
        rst_n = 1'b0;
        #1;
        chk("arst_nd", int'(bus.o_nd), 0);
        chk("arst_last", int'(bus.o_last), 0);
        chk("arst_ready", int'(bus.o_ready), 0);
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    abort = 0;
    @(negedge clk);
    chk("post_reset_nd", int'(bus.o_nd), 0);
    new_frame();
    feed(0);
    wait_frame();
    mon_en = 0;

    // Small configuration: 2 columns, 1 row, 1 channel.
    s_mon = 1;
    @(negedge clk);
    bus_s.i_start = 1'b1;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    sp = 0;
    g = 0;
    while (sp < 2 && g < 100) begin
      @(negedge clk);
      g++;
      if (bus_s.o_ready) begin
        bus_s.i_nd = 1'b1;
        bus_s.i_features[0] = (sp == 0) ? 16'sd5 : -16'sd7;
        sp++;
      end else begin
        bus_s.i_nd = 1'b0;
      end
    end
    @(negedge clk);
    bus_s.i_nd = 1'b0;
    g = 0;
    while (s_vals.size() < 8 && g < 100) begin @(negedge clk); g++; end
    repeat (4) @(negedge clk);
    chk("small_beats", s_vals.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < s_vals.size()) begin
        chk("small_data", s_vals[i], s_exp[i]);
        chk("small_last", s_lasts[i], int'(i == 7));
      end
    end
    chk("small_err", int'(bus_s.o_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/upsample_nn.md
# upsample_nn

Nearest-neighbour 2x upsampler for multi-channel feature streams; the inverse of the 2x2 pooling stage.
- Accepts a pooled feature map of NUM_IN_ROWS x NUM_IN_COLUMNS, one column beat per cycle carrying all channels.
- Emits each input row twice, with every column repeated twice.
- Output is a 2*NUM_IN_ROWS x 2*NUM_IN_COLUMNS raster stream, used in the decoder / feature-reconstruction path.
- Ping-pong row buffering lets input rows load while earlier rows replay.

## Interface
Parameters:
- DATA_WIDTH, 16, signed feature word width
- NUM_CHANNELS, 6, channels carried in parallel per beat
- NUM_IN_COLUMNS, 14, input columns per row (output row = 2*NUM_IN_COLUMNS)
- NUM_IN_ROWS, 14, input rows per frame (output frame = 2*NUM_IN_ROWS rows)

Ports:
- i_clk  in  1  single clock; all logic on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_nd  in  1  input beat valid
- i_features  in  NUM_CHANNELS x DATA_WIDTH signed  input beat, one column of all channels
- o_ready  out  1  input beat will be accepted this cycle
- o_features  out  NUM_CHANNELS x DATA_WIDTH signed  output beat, registered
- o_nd  out  1  output beat valid, one-cycle strobe per beat
- o_last  out  1  high with the final o_nd beat of a frame
- o_err  out  1  sticky flag: i_nd seen while o_ready low; cleared by an accepted i_start

## Operation
Top FSM:
- IDLE: i_start moves to RUN and clears o_err.
- RUN: returns to IDLE on the edge that emits the o_last beat.
- i_start in RUN is ignored.

Write side:
- Holds wr_sel, wr_col (0..NUM_IN_COLUMNS-1), in_row (0..NUM_IN_ROWS).
- A beat is accepted when i_nd && o_ready. It stores i_features into bank[wr_sel][wr_col] and increments wr_col.
- On the accept with wr_col==NUM_IN_COLUMNS-1: set full[wr_sel], toggle wr_sel, wr_col<=0, in_row+1.
- o_ready = RUN && !full[wr_sel] && in_row<NUM_IN_ROWS. Combinational from registered state.
- i_nd while o_ready low: the beat is dropped and o_err is set.

Read side:
- Holds rd_sel, out_col (0..2*NUM_IN_COLUMNS-1), pass (0/1), out_row.
- While full[rd_sel], every cycle: o_features <= bank[rd_sel][out_col>>1], o_nd <= 1, out_col+1.
- At out_col==2*NUM_IN_COLUMNS-1: out_col<=0, pass toggles.
- At end of pass 1: clear full[rd_sel], toggle rd_sel, out_row+1.
- o_last <= 1 on the final beat of pass 1 of input row NUM_IN_ROWS-1.
- No output backpressure: downstream always accepts.

Widths:
- Counters are sized $clog2(N+1) for terminal compare.
- Output column-to-buffer index is out_col>>1.
- Data is passed through unmodified: no arithmetic, no saturation.

Boundary conditions:
- Simultaneous write-fill of one bank and read-release of the other: both take effect on the same edge.
- A bank released at edge k is writable from the cycle after k (o_ready rises after k).
- Write and read never target the same bank while it is full.
- Both banks full: o_ready low until the read side releases one.

## Timing
- Reset values: o_features all 0, o_nd 0, o_last 0, o_err 0, o_ready 0. FSM is IDLE, banks empty, all counters 0.
- Latency: when the last column of a row is accepted at edge k, the first o_nd of that row's replay is high in the cycle after edge k+1.
- Each input row produces 4*NUM_IN_COLUMNS consecutive o_nd cycles, gap-free.
- When the next bank is already full, successive rows replay back-to-back with no idle cycle.
- Sustained throughput: one input row per 4*NUM_IN_COLUMNS cycles. o_ready deasserts accordingly.
- Reset mid-frame: all state returns to reset values immediately, asynchronously. Partially emitted rows are abandoned, with no o_last.

## Structure
- Shared package cnn_pkg holds:
  - DATA_WIDTH default
  - NUM_CHANNELS default
  - typedef feature_t (signed [DATA_WIDTH-1:0])
  - typedef feature_vec_t (feature_t [0:NUM_CHANNELS-1])
- Sub-module upsample_row_buf holds the two banks of NUM_IN_COLUMNS x feature_vec_t.
  - Ports: one write port (bank select, column, data, enable) and one registered read port (bank select, column).
  - Contents are not reset.
- The top holds the FSM, counters, full flags and the o_err / o_last logic.

## Test plan
- Reset then single frame, defaults: i_start, then feed input pixel (r,c) with channel ch = r*100+c*2+ch at every o_ready cycle. Required response:
  - exactly 784 o_nd beats;
  - beat at output (R,C) carries value (R>>1)*100+(C>>1)*2+ch;
  - o_last only on beat 784.
- Gap-free replay: input beats driven every o_ready cycle. Required response:
  - o_nd continuous from the first beat to o_last, 784 consecutive cycles;
  - first o_nd in the cycle after the edge following acceptance of input row 0 col 13.
- Overflow: hold i_nd=1 continuously. Required response:
  - o_err sets when o_ready first drops (after 28 accepted beats);
  - dropped beats are never stored;
  - output still matches accepted data.
- Ignored restart: pulse i_start at output beat 100. Frame continues unchanged, 784 beats, single o_last.
- Async reset at output beat 300: o_nd, o_last, o_ready drop at once. A subsequent i_start and full frame produces a correct 784-beat output.
- Parameter sweep NUM_IN_COLUMNS=2, NUM_IN_ROWS=1, NUM_CHANNELS=1: inputs 5, -7 produce output 5,5,-7,-7,5,5,-7,-7 with o_last on the 8th beat.
